// File: rtl/johnson_pkg.sv
// ---------------------------------------------------------------------------
// johnson_pkg
// Shared definitions for the Johnson-code decoder block.
//   state_e          : tracker FSM states (HUNT after reset, LOCKED once the
//                      observed counter has stepped correctly often enough)
//   DEFAULT_WIDTH    : default Johnson code width
//   DEFAULT_LOCK_CNT : default number of consecutive correct steps to lock
//   ERR_MAX          : saturation value of the 8-bit error counter
//   idxWidth()       : bits needed to hold a sequence index 0..2*width-1
// ---------------------------------------------------------------------------
package johnson_pkg;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  localparam int DEFAULT_WIDTH    = 4;
  localparam int DEFAULT_LOCK_CNT = 3;
  localparam logic [7:0] ERR_MAX  = 8'hFF;

  // A Johnson counter of width W walks through 2*W states, so the index
  // needs enough bits to hold 2*W-1.
  function automatic int idxWidth(input int width);
    return $clog2(2 * width);
  endfunction

endpackage

// File: rtl/johnson_decoder_if.sv
// ---------------------------------------------------------------------------
// johnson_decoder_if
// Bundles the sample input and the decoded status outputs of the decoder.
//   in_valid  : q_in is to be sampled this cycle          (master -> slave)
//   q_in      : Johnson code from the observed counter    (master -> slave)
//   idx_out   : decoded sequence index                    (slave -> master)
//   idx_valid : pulse, idx_out holds a fresh legal sample (slave -> master)
//   illegal   : pulse, the sample was not a Johnson code  (slave -> master)
//   step_err  : pulse, legal code but not hold/next       (slave -> master)
//   locked    : level, tracker is locked                  (slave -> master)
//   err_count : saturating count of errors while locked  (slave -> master)
// The master modport is the stimulus side, the slave modport the decoder.
// ---------------------------------------------------------------------------
interface johnson_decoder_if
  import johnson_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int IW    = idxWidth(WIDTH)
);

  logic             in_valid;
  logic [WIDTH-1:0] q_in;
  logic [IW-1:0]    idx_out;
  logic             idx_valid;
  logic             illegal;
  logic             step_err;
  logic             locked;
  logic [7:0]       err_count;

  modport master (
    output in_valid,
    output q_in,
    input  idx_out,
    input  idx_valid,
    input  illegal,
    input  step_err,
    input  locked,
    input  err_count
  );

  modport slave (
    input  in_valid,
    input  q_in,
    output idx_out,
    output idx_valid,
    output illegal,
    output step_err,
    output locked,
    output err_count
  );

endinterface

// File: rtl/johnson_decode.sv
// ---------------------------------------------------------------------------
// johnson_decode
// Purely combinational Johnson code decoder.
//   q_i     : Johnson code to decode
//   idx_o   : sequence index 0..2*WIDTH-1 the code would occupy
//   legal_o : 1 when q_i really is the Johnson code of idx_o
// ---------------------------------------------------------------------------
module johnson_decode
  import johnson_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int IW    = idxWidth(WIDTH)
) (
  input  logic [WIDTH-1:0] q_i,
  output logic [IW-1:0]    idx_o,
  output logic             legal_o
);

  int               onesCnt;
  int               idxInt;
  logic [WIDTH-1:0] regen;

  // The first half of the sequence fills with ones from the LSB (MSB still
  // clear), so the index is just the number of ones.  The second half drains
  // ones from the LSB (MSB set), so the index is WIDTH plus the number of
  // zeros, i.e. 2*WIDTH minus the number of ones.  The index is then turned
  // back into its ideal code; any mismatch means the input was not a Johnson
  // code at all (e.g. 0101 decodes to 2 but index 2 is 0011).
  always_comb begin
    onesCnt = 0;
    for (int i = 0; i < WIDTH; i++) begin
      if (q_i[i]) begin
        onesCnt = onesCnt + 1;
      end
    end

    if (q_i[WIDTH-1]) begin
      idxInt = 2 * WIDTH - onesCnt;
    end else begin
      idxInt = onesCnt;
    end

    regen = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (idxInt <= WIDTH) begin
        regen[i] = (i < idxInt);
      end else begin
        regen[i] = (i >= idxInt - WIDTH);
      end
    end

    idx_o   = IW'(idxInt);
    legal_o = (regen == q_i);
  end

endmodule

// File: rtl/johnson_decoder.sv
// ---------------------------------------------------------------------------
// johnson_decoder
// Watches a Johnson counter, decodes each sampled code into its sequence
// index and tracks whether the counter is stepping correctly.  After
// LOCK_CNT consecutive correct steps the tracker locks; while locked every
// illegal code or wrong step is counted in a saturating error counter and
// drops the tracker back into HUNT.  Every output is registered, so a sample
// taken in one cycle is reported in the next.
//   clk   : sole clock, rising edge
//   reset : synchronous, active-high
//   bus   : johnson_decoder_if slave modport (sample in, status out)
// ---------------------------------------------------------------------------
module johnson_decoder
  import johnson_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int LOCK_CNT = DEFAULT_LOCK_CNT,
  parameter int IW       = idxWidth(WIDTH)
) (
  input logic               clk,
  input logic               reset,
  johnson_decoder_if.slave  bus
);

  localparam logic [IW-1:0] LAST_IDX = IW'(2 * WIDTH - 1);
  localparam logic [3:0]    LOCK_RUN = 4'(LOCK_CNT);

  state_e        state_q, state_d;
  logic          prevValid_q, prevValid_d;
  logic [IW-1:0] prev_q, prev_d;
  logic [3:0]    run_q, run_d;
  logic [IW-1:0] idxOut_q, idxOut_d;
  logic          idxValid_q, idxValid_d;
  logic          illegal_q, illegal_d;
  logic          stepErr_q, stepErr_d;
  logic [7:0]    errCount_q, errCount_d;

  logic [IW-1:0] decIdx;
  logic          decLegal;
  logic [IW-1:0] prevNext;
  logic          isStep;
  logic          isHold;
  logic [3:0]    runInc;
  logic [7:0]    errInc;

  johnson_decode #(
    .WIDTH (WIDTH),
    .IW    (IW)
  ) u_decode (
    .q_i     (bus.q_in),
    .idx_o   (decIdx),
    .legal_o (decLegal)
  );

  // Classify the current sample relative to the previous index.  Both
  // qualifiers need a valid previous index; the successor wraps from the
  // last index back to 0 so a free-running counter keeps stepping correctly.
  always_comb begin
    prevNext = (prev_q == LAST_IDX) ? '0 : prev_q + IW'(1);
    isStep   = prevValid_q && (decIdx == prevNext);
    isHold   = prevValid_q && (decIdx == prev_q);
    runInc   = run_q + 4'd1;
    errInc   = (errCount_q == ERR_MAX) ? ERR_MAX : errCount_q + 8'd1;
  end

  // Next-state and output logic.  Everything holds by default and the three
  // pulses clear, which covers idle cycles.  An illegal code takes priority
  // over any step check and leaves idx_out and the previous index untouched
  // apart from invalidating it.  Errors are only counted while locked.
  always_comb begin
    state_d     = state_q;
    prevValid_d = prevValid_q;
    prev_d      = prev_q;
    run_d       = run_q;
    idxOut_d    = idxOut_q;
    idxValid_d  = 1'b0;
    illegal_d   = 1'b0;
    stepErr_d   = 1'b0;
    errCount_d  = errCount_q;

    if (bus.in_valid) begin
      if (!decLegal) begin
        illegal_d   = 1'b1;
        prevValid_d = 1'b0;
        run_d       = '0;
        if (state_q == LOCKED) begin
          errCount_d = errInc;
          state_d    = HUNT;
        end
      end else begin
        idxValid_d = 1'b1;
        idxOut_d   = decIdx;
        unique case (state_q)
          HUNT: begin
            if (isStep) begin
              prev_d = decIdx;
              run_d  = runInc;
              if (runInc >= LOCK_RUN) begin
                state_d = LOCKED;
              end
            end else if (!isHold) begin
              prev_d      = decIdx;
              prevValid_d = 1'b1;
              run_d       = '0;
            end
          end
          LOCKED: begin
            prev_d = decIdx;
            if (!isStep && !isHold) begin
              stepErr_d  = 1'b1;
              errCount_d = errInc;
              run_d      = '0;
              state_d    = HUNT;
            end
          end
          default: begin
            state_d = HUNT;
          end
        endcase
      end
    end
  end

  // State register with synchronous reset overriding any sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= HUNT;
      prevValid_q <= 1'b0;
      prev_q      <= '0;
      run_q       <= '0;
      idxOut_q    <= '0;
      idxValid_q  <= 1'b0;
      illegal_q   <= 1'b0;
      stepErr_q   <= 1'b0;
      errCount_q  <= '0;
    end else begin
      state_q     <= state_d;
      prevValid_q <= prevValid_d;
      prev_q      <= prev_d;
      run_q       <= run_d;
      idxOut_q    <= idxOut_d;
      idxValid_q  <= idxValid_d;
      illegal_q   <= illegal_d;
      stepErr_q   <= stepErr_d;
      errCount_q  <= errCount_d;
    end
  end

  assign bus.idx_out   = idxOut_q;
  assign bus.idx_valid = idxValid_q;
  assign bus.illegal   = illegal_q;
  assign bus.step_err  = stepErr_q;
  assign bus.locked    = (state_q == LOCKED);
  assign bus.err_count = errCount_q;

endmodule

// File: tb/tb_johnson_decoder.sv
// ---------------------------------------------------------------------------
// tb_johnson_decoder
// Drives the Johnson decoder with directed scenarios and random samples and
// compares every output against a behavioural model built from a table of
// the Johnson sequence.
// ---------------------------------------------------------------------------
module tb_johnson_decoder;
  import johnson_pkg::*;

  localparam int W  = 4;
  localparam int LC = 3;
  localparam int N  = 2 * W;

  logic clk;
  logic reset;

  johnson_decoder_if #(.WIDTH(W)) bus ();

  johnson_decoder #(
    .WIDTH    (W),
    .LOCK_CNT (LC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int passes = 0;

  logic [W-1:0] codes [N];

  bit mLocked;
  bit mPrevValid;
  int mPrev;
  int mRun;
  int mErr;
  int mIdxOut;
  bit mIdxValid;
  bit mIllegal;
  bit mStepErr;

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Guard against a hung run.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts and reports.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed === expected) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  // Johnson sequence built by shifting in the inverted MSB from all-zeros.
  task automatic buildTable();
    logic [W-1:0] c;
    c = '0;
    for (int k = 0; k < N; k++) begin
      codes[k] = c;
      c = {c[W-2:0], ~c[W-1]};
    end
  endtask

  function automatic int lookup(input logic [W-1:0] q);
    int found;
    found = -1;
    for (int k = 0; k < N; k++) begin
      if (codes[k] == q) found = k;
    end
    return found;
  endfunction

  task automatic modelReset();
    mLocked    = 0;
    mPrevValid = 0;
    mPrev      = 0;
    mRun       = 0;
    mErr       = 0;
    mIdxOut    = 0;
    mIdxValid  = 0;
    mIllegal   = 0;
    mStepErr   = 0;
  endtask

  task automatic modelStep(input bit v, input logic [W-1:0] q);
    int  idx;
    bit  fwd;
    bit  hold;
    mIdxValid = 0;
    mIllegal  = 0;
    mStepErr  = 0;
    if (v) begin
      idx = lookup(q);
      if (idx < 0) begin
        mIllegal = 1;
        if (mLocked) begin
          mErr    = (mErr < 255) ? mErr + 1 : 255;
          mLocked = 0;
        end
        mPrevValid = 0;
        mRun       = 0;
      end else begin
        mIdxValid = 1;
        mIdxOut   = idx;
        fwd  = mPrevValid && (idx == (mPrev + 1) % N);
        hold = mPrevValid && (idx == mPrev);
        if (mLocked) begin
          if (!(fwd || hold)) begin
            mStepErr = 1;
            mErr     = (mErr < 255) ? mErr + 1 : 255;
            mLocked  = 0;
            mRun     = 0;
          end
        end else if (fwd) begin
          mRun++;
          if (mRun >= LC) mLocked = 1;
        end else if (!hold) begin
          mRun = 0;
        end
        mPrev      = idx;
        mPrevValid = 1;
      end
    end
  endtask

  task automatic compareAll();
    checkOutput("idx_out",   32'(bus.idx_out),   32'(mIdxOut));
    checkOutput("idx_valid", 32'(bus.idx_valid), 32'(mIdxValid));
    checkOutput("illegal",   32'(bus.illegal),   32'(mIllegal));
    checkOutput("step_err",  32'(bus.step_err),  32'(mStepErr));
    checkOutput("locked",    32'(bus.locked),    32'(mLocked));
    checkOutput("err_count", 32'(bus.err_count), 32'(mErr));
  endtask

  // One sample: drive, clock, update the model, then check away from the edge.
  task automatic applyStimulus(input bit v, input logic [W-1:0] q);
    bus.in_valid = v;
    bus.q_in     = q;
    @(posedge clk);
    modelStep(v, q);
    #1;
    compareAll();
  endtask

  task automatic applyReset(input int cycles);
    reset        = 1'b1;
    bus.in_valid = 1'b1;
    bus.q_in     = W'($urandom);
    repeat (cycles) @(posedge clk);
    modelReset();
    #1;
    compareAll();
    reset = 1'b0;
  endtask

  function automatic logic [W-1:0] illegalCode();
    logic [W-1:0] q;
    q = W'($urandom);
    for (int t = 0; t < 64 && lookup(q) >= 0; t++) q = W'($urandom);
    if (lookup(q) >= 0) q = 4'b0101;
    return q;
  endfunction

  initial begin
    int guard;
    int cursor;
    int r;
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.q_in     = '0;
    buildTable();
    modelReset();

    // Reset held two cycles, then idle.
    applyReset(2);
    applyStimulus(0, 4'b0000);
    checkOutput("rst_locked", 32'(bus.locked), 32'd0);
    checkOutput("rst_err",    32'(bus.err_count), 32'd0);

    // Lock on 0..3; locked rises with idx 3.
    applyStimulus(1, 4'b0000);
    applyStimulus(1, 4'b0001);
    applyStimulus(1, 4'b0011);
    checkOutput("pre_lock", 32'(bus.locked), 32'd0);
    applyStimulus(1, 4'b0111);
    checkOutput("lock_idx3", 32'(bus.idx_out), 32'd3);
    checkOutput("lock_rise", 32'(bus.locked), 32'd1);

    // Walk to idx 7 and wrap to 0 while locked.
    applyStimulus(1, 4'b1111);
    applyStimulus(1, 4'b1110);
    applyStimulus(1, 4'b1100);
    applyStimulus(1, 4'b1000);
    applyStimulus(1, 4'b0000);
    checkOutput("wrap_idx",    32'(bus.idx_out),  32'd0);
    checkOutput("wrap_steperr", 32'(bus.step_err), 32'd0);
    checkOutput("wrap_locked", 32'(bus.locked),   32'd1);

    // Locked at idx 2, illegal 0101.
    applyStimulus(1, 4'b0001);
    applyStimulus(1, 4'b0011);
    applyStimulus(1, 4'b0101);
    checkOutput("ill_pulse",  32'(bus.illegal),   32'd1);
    checkOutput("ill_steperr", 32'(bus.step_err), 32'd0);
    checkOutput("ill_err",    32'(bus.err_count), 32'd1);
    checkOutput("ill_locked", 32'(bus.locked),    32'd0);
    checkOutput("ill_idx",    32'(bus.idx_out),   32'd2);

    // Relock on 0..3, wrong step to 6, then relock via 7,0,1.
    applyStimulus(1, 4'b0000);
    applyStimulus(1, 4'b0001);
    applyStimulus(1, 4'b0011);
    applyStimulus(1, 4'b0111);
    applyStimulus(1, 4'b1100);
    checkOutput("step_pulse",  32'(bus.step_err),  32'd1);
    checkOutput("step_err",    32'(bus.err_count), 32'd2);
    checkOutput("step_hunt",   32'(bus.locked),    32'd0);
    applyStimulus(1, 4'b1000);
    applyStimulus(1, 4'b0000);
    applyStimulus(1, 4'b0001);
    checkOutput("relock", 32'(bus.locked), 32'd1);

    // Random mix of steps, holds, jumps, illegal codes and idle cycles.
    cursor = 1;
    for (int n = 0; n < 600; n++) begin
      r = $urandom_range(0, 99);
      if (r < 50) begin
        cursor = (cursor + 1) % N;
        applyStimulus(1, codes[cursor]);
      end else if (r < 60) begin
        applyStimulus(1, codes[cursor]);
      end else if (r < 70) begin
        cursor = $urandom_range(0, N - 1);
        applyStimulus(1, codes[cursor]);
      end else if (r < 80) begin
        applyStimulus(1, illegalCode());
      end else begin
        applyStimulus(0, W'($urandom));
      end
    end

    // Drive the error counter into saturation with lock / wrong-step cycles.
    guard = 0;
    while (mErr < 255 && guard < 5000) begin
      if (!mPrevValid) applyStimulus(1, codes[0]);
      else if (mLocked) applyStimulus(1, codes[(mPrev + 3) % N]);
      else applyStimulus(1, codes[(mPrev + 1) % N]);
      guard++;
    end
    checkOutput("sat_reach", 32'(bus.err_count), 32'd255);
    guard = 0;
    while (!mLocked && guard < 20) begin
      if (!mPrevValid) applyStimulus(1, codes[0]);
      else applyStimulus(1, codes[(mPrev + 1) % N]);
      guard++;
    end
    checkOutput("sat_locked", 32'(bus.locked), 32'd1);
    applyStimulus(1, codes[(mPrev + 3) % N]);
    checkOutput("sat_hold",   32'(bus.err_count), 32'd255);
    checkOutput("sat_pulse",  32'(bus.step_err),  32'd1);

    // Relock, then reset while locked with a valid sample present.
    guard = 0;
    while (!mLocked && guard < 20) begin
      applyStimulus(1, codes[(mPrev + 1) % N]);
      guard++;
    end
    checkOutput("pre_rst_locked", 32'(bus.locked), 32'd1);
    applyReset(1);
    checkOutput("rst2_locked", 32'(bus.locked),    32'd0);
    checkOutput("rst2_err",    32'(bus.err_count), 32'd0);
    checkOutput("rst2_idx",    32'(bus.idx_out),   32'd0);
    applyStimulus(1, codes[5]);
    applyStimulus(1, codes[6]);

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/johnson_decoder.md
JOHNSON_DECODER -- requirements
Module: johnson_decoder

Interface
REQ-001 Parameter WIDTH, default 4, Johnson code width (legal range 2..16).
REQ-002 Parameter LOCK_CNT, default 3, consecutive correct steps required to declare lock (1..15).
REQ-003 Parameter IW = $clog2(2*WIDTH), derived, index width (3 for WIDTH=4).
REQ-004 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-005 Port: reset  input  1  synchronous, active-high reset.
REQ-006 Port: in_valid  input  1  q_in is sampled this cycle.
REQ-007 Port: q_in  input  WIDTH  Johnson code from the counter under observation.
REQ-008 Port: idx_out  output  IW  decoded sequence index 0..2*WIDTH-1.
REQ-009 Port: idx_valid  output  1  one-cycle pulse; idx_out holds a legal decoded sample.
REQ-010 Port: illegal  output  1  one-cycle pulse; the sampled code is not a Johnson code.
REQ-011 Port: step_err  output  1  one-cycle pulse; legal code but not hold/next of the previous index.
REQ-012 Port: locked  output  1  level; FSM in LOCKED.
REQ-013 Port: err_count  output  8  errors counted while locked, saturating.

Function
REQ-014 Johnson sequence: next = {q[WIDTH-2:0], ~q[WIDTH-1]} from 0; WIDTH=4: 0000,0001,0011,0111,1111,1110,1100,1000 = idx 0..7.
REQ-015 Decode: q[WIDTH-1]=0 -> idx = popcount(q); q[WIDTH-1]=1 -> idx = WIDTH + count of zeros.
REQ-016 Legal iff q_in equals the regenerated Johnson code of its decoded idx; 2*WIDTH of 2^WIDTH codes are legal.
REQ-017 All outputs are registered: a sample taken in cycle N appears in cycle N+1.
REQ-018 in_valid=0: no state change; idx_valid, illegal, step_err = 0 next cycle; idx_out holds.
REQ-019 Correct step: idx == (prev+1) mod 2*WIDTH; wrap 2*WIDTH-1 -> 0 is correct.
REQ-020 Hold: idx == prev; legal, no error, does not advance the lock count.
REQ-021 Illegal has priority: an illegal sample pulses illegal only, never step_err; prev and idx_out unchanged.
REQ-022 FSM states HUNT (reset state) and LOCKED.
REQ-023 HUNT, legal sample: if there is no prev or the step is wrong, prev := idx and run := 0; correct step -> run+1; hold -> run unchanged.
REQ-024 HUNT -> LOCKED when run reaches LOCK_CNT; locked asserts in the same cycle as that sample's idx_valid.
REQ-025 HUNT, illegal sample: run := 0 and prev is invalidated; no step_err in HUNT; err_count unchanged.
REQ-026 LOCKED, correct step or hold: prev := idx; stay LOCKED.
REQ-027 LOCKED, wrong step: pulse step_err, err_count+1, prev := idx, run := 0, go to HUNT.
REQ-028 LOCKED, illegal sample: pulse illegal, err_count+1, prev invalidated, run := 0, go to HUNT.
REQ-029 err_count saturates at 255 and never wraps.

Reset
REQ-030 reset=1 at an edge overrides all inputs, including mid-sequence and while LOCKED.
REQ-031 Reset values: state HUNT, prev invalid, run 0, idx_out 0, idx_valid 0, illegal 0, step_err 0, locked 0, err_count 0.

Structure
REQ-032 Package johnson_pkg holds the state enum (HUNT, LOCKED), the default WIDTH/LOCK_CNT constants and the index-width function.
REQ-033 Sub-module johnson_decode: purely combinational; q -> idx, legal; instantiated once.

Verification
REQ-034 Reset held 2 cycles, then in_valid=0 -> all outputs 0, locked=0, err_count=0.
REQ-035 Feed 0000,0001,0011,0111 on consecutive valid cycles -> idx 0,1,2,3 one cycle later each; locked rises with idx 3.
REQ-036 Locked at idx 7 (1000), feed 0000 -> idx_valid with idx 0, no step_err, locked stays 1 (wrap).
REQ-037 Locked at idx 2, feed 0101 -> illegal pulse, step_err 0, err_count 1, locked falls, idx_out stays 2.
REQ-038 Locked at idx 3, feed 1100 (idx 6) -> step_err pulse, err_count+1, HUNT; then 1000,0000,0001 -> relock.
REQ-039 Locked with err_count forced to 255 by 255 errors, one more error -> err_count stays 255; reset asserted while LOCKED -> all reset values next cycle.
